// File: rtl/mt_pkg.sv
// mt_pkg: constants and the checker state type shared by the memory-tester
// blocks (sequence checker, game controller, display path).
package mt_pkg;

    localparam int MAX_DIGITS = 7;
    localparam int DIGIT_W    = 4;
    localparam int STORE_W    = MAX_DIGITS * DIGIT_W;
    localparam int IDX_W      = 3;
    localparam int LEVEL_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } chk_state_t;

    // Level 0 still plays one digit; anything past the store depth plays all of it.
    function automatic logic [IDX_W-1:0] clamp_len(input logic [LEVEL_W-1:0] level);
        if (level == '0)
            return IDX_W'(1);
        else if (level > LEVEL_W'(MAX_DIGITS))
            return IDX_W'(MAX_DIGITS);
        else
            return level[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/digit_sel.sv
// digit_sel: picks digit k of an L-digit sequence out of the packed store.
// The last-generated digit sits at the LSBs, so digit k lives (L-1-k) nibbles up.
module digit_sel
    import mt_pkg::*;
(
    input  logic [STORE_W-1:0] snapshot,
    input  logic [IDX_W-1:0]   len,
    input  logic [IDX_W-1:0]   idx,
    output logic [DIGIT_W-1:0] digit
);

    logic [IDX_W-1:0] pos;

    // Shift the wanted nibble down to bit 0 and keep only that nibble.
    always_comb begin
        pos   = len - idx - IDX_W'(1);
        digit = DIGIT_W'(snapshot >> (pos * DIGIT_W));
    end

endmodule

// File: rtl/seq_checker.sv
// seq_checker: compares keypad entries digit by digit against the captured
// sequence and produces the held win/loose verdicts.
// Optional feature macro: SEQ_CHECKER_RETRY_EN (one forgiven miss per round,
// reported on retry_used).
module seq_checker
    import mt_pkg::*;
(
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic               logout,
    input  logic [STORE_W-1:0] store_reg,
    input  logic [LEVEL_W-1:0] level_num,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               time_out,
    output logic               key_ack,
    output logic [IDX_W-1:0]   digit_idx,
    output logic               busy,
    output logic               win,
`ifdef SEQ_CHECKER_RETRY_EN
    output logic               loose,
    output logic               retry_used
`else
    output logic               loose
`endif
);

    chk_state_t         state, state_n;
    logic [STORE_W-1:0] snap, snap_n;
    logic [IDX_W-1:0]   len, len_n;
    logic [IDX_W-1:0]   idx_n;
    logic [DIGIT_W-1:0] exp_digit;
    logic               ack_n, busy_n, win_n, loose_n;
`ifdef SEQ_CHECKER_RETRY_EN
    logic               retry_n;
`endif

    digit_sel u_digit_sel (
        .snapshot (snap),
        .len      (len),
        .idx      (digit_idx),
        .digit    (exp_digit)
    );

    // Next-state and next-output decode; logout beats start, start beats keys/timeout.
    always_comb begin
        state_n = state;
        snap_n  = snap;
        len_n   = len;
        idx_n   = digit_idx;
        ack_n   = 1'b0;
        win_n   = win;
        loose_n = loose;
`ifdef SEQ_CHECKER_RETRY_EN
        retry_n = retry_used;
`endif
        if (logout) begin
            state_n = IDLE;
            idx_n   = '0;
            win_n   = 1'b0;
            loose_n = 1'b0;
`ifdef SEQ_CHECKER_RETRY_EN
            retry_n = 1'b0;
`endif
        end else if (start) begin
            state_n = ENTRY;
            snap_n  = store_reg;
            len_n   = clamp_len(level_num);
            idx_n   = '0;
            win_n   = 1'b0;
            loose_n = 1'b0;
`ifdef SEQ_CHECKER_RETRY_EN
            retry_n = 1'b0;
`endif
        end else if (state == ENTRY) begin
            if (time_out) begin
                state_n = LOSE;
                loose_n = 1'b1;
            end else if (key_valid) begin
                ack_n = 1'b1;
                if (key_digit == exp_digit) begin
                    if (digit_idx == len - IDX_W'(1)) begin
                        state_n = WIN;
                        win_n   = 1'b1;
                    end else begin
                        idx_n = digit_idx + IDX_W'(1);
                    end
                end
`ifdef SEQ_CHECKER_RETRY_EN
                else if (!retry_used) begin
                    retry_n = 1'b1;
                    idx_n   = '0;
                end
`endif
                else begin
                    state_n = LOSE;
                    loose_n = 1'b1;
                end
            end
        end
        busy_n = (state_n == ENTRY);
    end

    // State, snapshot and all outputs are registered together.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snap      <= '0;
            len       <= IDX_W'(1);
            digit_idx <= '0;
            key_ack   <= 1'b0;
            busy      <= 1'b0;
            win       <= 1'b0;
            loose     <= 1'b0;
`ifdef SEQ_CHECKER_RETRY_EN
            retry_used <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            snap      <= snap_n;
            len       <= len_n;
            digit_idx <= idx_n;
            key_ack   <= ack_n;
            busy      <= busy_n;
            win       <= win_n;
            loose     <= loose_n;
`ifdef SEQ_CHECKER_RETRY_EN
            retry_used <= retry_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: directed scenarios plus randomized rounds, compared every
// cycle against a round-level reference model of the checker.
module tb_seq_checker;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;
`ifdef SEQ_CHECKER_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    logic        clock, rst, start, logout, key_valid, time_out;
    logic [27:0] store_reg;
    logic [3:0]  level_num, key_digit;
    logic        key_ack, busy, win, loose;
    logic [2:0]  digit_idx;
`ifdef SEQ_CHECKER_RETRY_EN
    logic        retry_used;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode, m_len, m_pos;
    int m_seq[7];
    bit m_ack, m_win, m_lose, m_retry;

    seq_checker dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .logout     (logout),
        .store_reg  (store_reg),
        .level_num  (level_num),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .time_out   (time_out),
        .key_ack    (key_ack),
        .digit_idx  (digit_idx),
        .busy       (busy),
        .win        (win),
`ifdef SEQ_CHECKER_RETRY_EN
        .loose      (loose),
        .retry_used (retry_used)
`else
        .loose      (loose)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mode  = M_IDLE;
        m_len   = 1;
        m_pos   = 0;
        m_ack   = 1'b0;
        m_win   = 1'b0;
        m_lose  = 1'b0;
        m_retry = 1'b0;
        foreach (m_seq[k]) m_seq[k] = 0;
    endtask

    // One clock of the round-level game: unpack the sequence at start, walk a
    // position pointer on correct keys, finish on full match, miss or timeout.
    task automatic modelStep(input bit st, input bit lo, input bit kv, input logic [3:0] kd,
                             input bit to, input logic [27:0] sr, input logic [3:0] lv);
        m_ack = 1'b0;
        if (lo) begin
            m_mode = M_IDLE; m_pos = 0; m_win = 0; m_lose = 0; m_retry = 0;
        end else if (st) begin
            m_len = (lv == 0) ? 1 : ((lv > 7) ? 7 : int'(lv));
            for (int k = 0; k < m_len; k++)
                m_seq[k] = int'((sr >> (4 * (m_len - 1 - k))) & 28'hF);
            m_mode = M_PLAY; m_pos = 0; m_win = 0; m_lose = 0; m_retry = 0;
        end else if (m_mode == M_PLAY) begin
            if (to) begin
                m_lose = 1'b1; m_mode = M_DONE;
            end else if (kv) begin
                m_ack = 1'b1;
                if (int'(kd) == m_seq[m_pos]) begin
                    if (m_pos == m_len - 1) begin
                        m_win = 1'b1; m_mode = M_DONE;
                    end else begin
                        m_pos++;
                    end
                end else if (RETRY_ON && !m_retry) begin
                    m_retry = 1'b1; m_pos = 0;
                end else begin
                    m_lose = 1'b1; m_mode = M_DONE;
                end
            end
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ":key_ack"}, 32'(key_ack), 32'(m_ack));
        checkOutput({where, ":digit_idx"}, 32'(digit_idx), 32'(m_pos));
        checkOutput({where, ":busy"}, 32'(busy), 32'(m_mode == M_PLAY));
        checkOutput({where, ":win"}, 32'(win), 32'(m_win));
        checkOutput({where, ":loose"}, 32'(loose), 32'(m_lose));
`ifdef SEQ_CHECKER_RETRY_EN
        checkOutput({where, ":retry_used"}, 32'(retry_used), 32'(m_retry));
`endif
    endtask

    // Drive one cycle of inputs at the falling edge, step the model at the
    // rising edge, and compare just after it; pulses are dropped afterwards.
    task automatic applyStimulus(input bit st, input bit lo, input bit kv, input logic [3:0] kd,
                                 input bit to, input logic [27:0] sr, input logic [3:0] lv,
                                 input string where);
        @(negedge clock);
        start = st; logout = lo; key_valid = kv; key_digit = kd;
        time_out = to; store_reg = sr; level_num = lv;
        @(posedge clock);
        modelStep(st, lo, kv, kd, to, sr, lv);
        #1;
        checkAll(where);
        start = 1'b0; logout = 1'b0; key_valid = 1'b0; time_out = 1'b0;
    endtask

    task automatic beginRound(input logic [27:0] sr, input logic [3:0] lv);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, sr, lv, "start");
    endtask

    task automatic pressKey(input logic [3:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0, store_reg, level_num, "key");
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, store_reg, level_num, "idle");
    endtask

    initial begin
        bit st, lo, kv, to;
        logic [3:0] kd;

        start = 0; logout = 0; key_valid = 0; key_digit = 0; time_out = 0;
        store_reg = '0; level_num = '0;
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkAll("reset");
        @(negedge clock);
        rst = 1'b0;

        // Full match of a 3-digit sequence.
        beginRound(28'h0000357, 4'd3);
        checkOutput("tp1_busy_after_start", 32'(busy), 32'd1);
        pressKey(4'd3);
        checkOutput("tp1_idx1", 32'(digit_idx), 32'd1);
        pressKey(4'd5);
        checkOutput("tp1_idx2", 32'(digit_idx), 32'd2);
        pressKey(4'd7);
        checkOutput("tp1_win", 32'(win), 32'd1);
        checkOutput("tp1_busy_done", 32'(busy), 32'd0);
        idleCycle();

        // Miss on the second key, later keys ignored.
        beginRound(28'h0000357, 4'd3);
        pressKey(4'd3);
        pressKey(4'd6);
        checkOutput("tp2_loose", 32'(loose), 32'd1);
        pressKey(4'd7);
        checkOutput("tp2_no_ack", 32'(key_ack), 32'd0);

        // Timeout collides with a key.
        beginRound(28'h0000357, 4'd3);
        pressKey(4'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 1'b1, store_reg, level_num, "to_key");
        checkOutput("tp3_loose", 32'(loose), 32'd1);
        checkOutput("tp3_no_ack", 32'(key_ack), 32'd0);
        checkOutput("tp3_idx", 32'(digit_idx), 32'd1);

        // Length clamps at both ends.
        beginRound(28'h1234569, 4'd0);
        pressKey(4'd9);
        checkOutput("tp4_len0_win", 32'(win), 32'd1);
        beginRound(28'h1234567, 4'd12);
        for (int d = 1; d <= 7; d++) begin
            pressKey(4'(d));
            if (d == 6) checkOutput("tp4_not_yet", 32'(win), 32'd0);
        end
        checkOutput("tp4_len12_win", 32'(win), 32'd1);

        // Logout mid-entry.
        beginRound(28'h0000357, 4'd3);
        pressKey(4'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, store_reg, level_num, "logout");
        checkOutput("tp5_logout_busy", 32'(busy), 32'd0);
        checkOutput("tp5_logout_idx", 32'(digit_idx), 32'd0);

        // Asynchronous reset between edges.
        beginRound(28'h0000357, 4'd3);
        pressKey(4'd3);
        @(negedge clock);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("async_rst");
        checkOutput("tp5_async_idx", 32'(digit_idx), 32'd0);
        checkOutput("tp5_async_busy", 32'(busy), 32'd0);
        @(negedge clock);
        rst = 1'b0;

`ifdef SEQ_CHECKER_RETRY_EN
        // One forgiven miss, then a clean finish.
        beginRound(28'h0000048, 4'd2);
        pressKey(4'd4);
        pressKey(4'd9);
        checkOutput("retry_set", 32'(retry_used), 32'd1);
        checkOutput("retry_idx", 32'(digit_idx), 32'd0);
        checkOutput("retry_no_loose", 32'(loose), 32'd0);
        pressKey(4'd4);
        pressKey(4'd8);
        checkOutput("retry_win", 32'(win), 32'd1);
        // Second miss loses.
        beginRound(28'h0000048, 4'd2);
        checkOutput("retry_cleared", 32'(retry_used), 32'd0);
        pressKey(4'd4);
        pressKey(4'd9);
        pressKey(4'd4);
        pressKey(4'd9);
        checkOutput("retry_second_loose", 32'(loose), 32'd1);
`endif

        // Randomized rounds; store_reg and level_num churn every cycle.
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 99) < ((m_mode == M_PLAY) ? 2 : 25));
            lo = ($urandom_range(0, 199) == 0);
            to = ($urandom_range(0, 49) == 0);
            kv = ($urandom_range(0, 99) < 60);
            if (m_mode == M_PLAY && $urandom_range(0, 99) < 85)
                kd = 4'(m_seq[m_pos]);
            else
                kd = 4'($urandom_range(0, 15));
            applyStimulus(st, lo, kv, kd, to, 28'($urandom), 4'($urandom_range(0, 15)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
